// File: rtl/legv8_pkg.sv
// Shared opcode patterns, state encoding and datapath select encodings for the
// LEGv8 multi-cycle control unit.
package legv8_pkg;

  localparam int OPCODE_W = 11;
  localparam int STATE_W  = 4;
  localparam int RETIRE_W = 32;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_EXEC_R    = 4'd3,
    ST_WB_ALU    = 4'd4,
    ST_EXEC_ADDR = 4'd5,
    ST_MEM_RD    = 4'd6,
    ST_WB_MEM    = 4'd7,
    ST_MEM_WR    = 4'd8,
    ST_EXEC_CBZ  = 4'd9,
    ST_EXEC_B    = 4'd10
  } state_t;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_OFF  = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;
  localparam logic [10:0] OP_B    = 11'b00010100000;

  localparam logic [10:0] MASK_FULL = 11'b11111111111;
  localparam logic [10:0] MASK_CBZ  = 11'b11111111000;
  localparam logic [10:0] MASK_B    = 11'b11111100000;

  function automatic logic op_match(input logic [10:0] op,
                                    input logic [10:0] pat,
                                    input logic [10:0] mask);
    return ((op ^ pat) & mask) == 11'd0;
  endfunction

endpackage

// File: rtl/legv8_opcode_decoder.sv
// Combinational classification of the 11-bit LEGv8 opcode field into the
// instruction groups the control FSM sequences differently.
module legv8_opcode_decoder
  import legv8_pkg::*;
(
  input  logic [10:0] opcode,
  output logic        is_r,
  output logic        is_ldur,
  output logic        is_stur,
  output logic        is_cbz,
  output logic        is_b,
  output logic        illegal
);

  always_comb begin
    is_r    = op_match(opcode, OP_ADD, MASK_FULL) | op_match(opcode, OP_SUB, MASK_FULL) |
              op_match(opcode, OP_AND, MASK_FULL) | op_match(opcode, OP_ORR, MASK_FULL);
    is_ldur = op_match(opcode, OP_LDUR, MASK_FULL);
    is_stur = op_match(opcode, OP_STUR, MASK_FULL);
    is_cbz  = op_match(opcode, OP_CBZ, MASK_CBZ);
    is_b    = op_match(opcode, OP_B, MASK_B);
    illegal = ~(is_r | is_ldur | is_stur | is_cbz | is_b);
  end

endmodule

// File: rtl/legv8_multicycle_control.sv
// Multi-cycle main control FSM for the LEGv8 core: sequences the shared datapath
// through fetch/decode/execute/memory/writeback and counts retired instructions.
//
//   state     | meaning
//   IDLE      | held in reset, first cycle after release
//   FETCH     | read instruction, PC += 4, waits on MEM_READY
//   DECODE    | branch target into ALUOut, dispatch on opcode
//   EXEC_R    | register-register ALU operation
//   WB_ALU    | write ALUOut to register file
//   EXEC_ADDR | compute load/store address
//   MEM_RD    | data read, waits on MEM_READY
//   WB_MEM    | write MDR to register file
//   MEM_WR    | data write, waits on MEM_READY
//   EXEC_CBZ  | test reg for zero, conditional PC load
//   EXEC_B    | unconditional PC load
module legv8_multicycle_control
  import legv8_pkg::*;
#(
  parameter int OPCODE_W = 11,
  parameter int STATE_W  = 4,
  parameter int RETIRE_W = 32
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic [OPCODE_W-1:0] OPCODE,
  input  logic                ZERO,
  input  logic                MEM_READY,
  output logic                CONTROL_PCWRITE,
  output logic                CONTROL_IRWRITE,
  output logic                CONTROL_REG2LOC,
  output logic                CONTROL_REGWRITE,
  output logic                CONTROL_MEMREAD,
  output logic                CONTROL_MEMWRITE,
  output logic                CONTROL_MEMTOREG,
  output logic                CONTROL_ALUSRCA,
  output logic [1:0]          CONTROL_ALUSRCB,
  output logic [1:0]          CONTROL_ALUOP,
  output logic                CONTROL_PCSOURCE,
  output logic                INSTR_DONE,
  output logic                ILLEGAL_OP,
  output logic [STATE_W-1:0]  STATE,
  output logic [RETIRE_W-1:0] RETIRED
);

  state_t              state_q, state_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;

  logic is_r, is_ldur, is_stur, is_cbz, is_b, is_illegal;

  legv8_opcode_decoder u_dec (
    .opcode  (OPCODE),
    .is_r    (is_r),
    .is_ldur (is_ldur),
    .is_stur (is_stur),
    .is_cbz  (is_cbz),
    .is_b    (is_b),
    .illegal (is_illegal)
  );

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    CONTROL_PCWRITE  = 1'b0;
    CONTROL_IRWRITE  = 1'b0;
    CONTROL_REGWRITE = 1'b0;
    CONTROL_MEMREAD  = 1'b0;
    CONTROL_MEMWRITE = 1'b0;
    CONTROL_MEMTOREG = 1'b0;
    CONTROL_ALUSRCA  = 1'b0;
    CONTROL_ALUSRCB  = SRCB_REG;
    CONTROL_ALUOP    = ALUOP_ADD;
    CONTROL_PCSOURCE = 1'b0;
    INSTR_DONE       = 1'b0;
    ILLEGAL_OP       = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        CONTROL_MEMREAD = 1'b1;
        CONTROL_ALUSRCB = SRCB_FOUR;
        CONTROL_IRWRITE = MEM_READY;
        CONTROL_PCWRITE = MEM_READY;
        if (MEM_READY) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        CONTROL_ALUSRCB = SRCB_OFF;
        if (is_r)                   state_d = ST_EXEC_R;
        else if (is_ldur | is_stur) state_d = ST_EXEC_ADDR;
        else if (is_cbz)            state_d = ST_EXEC_CBZ;
        else if (is_b)              state_d = ST_EXEC_B;
        else begin
          ILLEGAL_OP = 1'b1;
          state_d    = ST_FETCH;
        end
      end
      ST_EXEC_R: begin
        CONTROL_ALUSRCA = 1'b1;
        CONTROL_ALUOP   = ALUOP_RTYPE;
        state_d         = ST_WB_ALU;
      end
      ST_WB_ALU: begin
        CONTROL_REGWRITE = 1'b1;
        INSTR_DONE       = 1'b1;
        state_d          = ST_FETCH;
      end
      ST_EXEC_ADDR: begin
        CONTROL_ALUSRCA = 1'b1;
        CONTROL_ALUSRCB = SRCB_IMM;
        state_d         = is_ldur ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        CONTROL_MEMREAD = 1'b1;
        if (MEM_READY) state_d = ST_WB_MEM;
      end
      ST_WB_MEM: begin
        CONTROL_REGWRITE = 1'b1;
        CONTROL_MEMTOREG = 1'b1;
        INSTR_DONE       = 1'b1;
        state_d          = ST_FETCH;
      end
      ST_MEM_WR: begin
        CONTROL_MEMWRITE = 1'b1;
        INSTR_DONE       = MEM_READY;
        if (MEM_READY) state_d = ST_FETCH;
      end
      ST_EXEC_CBZ: begin
        CONTROL_ALUSRCA  = 1'b1;
        CONTROL_ALUOP    = ALUOP_PASSB;
        CONTROL_PCSOURCE = 1'b1;
        CONTROL_PCWRITE  = ZERO;
        INSTR_DONE       = 1'b1;
        state_d          = ST_FETCH;
      end
      ST_EXEC_B: begin
        CONTROL_PCSOURCE = 1'b1;
        CONTROL_PCWRITE  = 1'b1;
        INSTR_DONE       = 1'b1;
        state_d          = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase

    // Opcode is only meaningful once the IR has been loaded.
    CONTROL_REG2LOC = (is_stur | is_cbz) & (state_q != ST_IDLE) & (state_q != ST_FETCH);
    retired_d       = retired_q + (INSTR_DONE ? RETIRE_W'(1) : RETIRE_W'(0));
  end

  assign STATE   = STATE_W'(state_q);
  assign RETIRED = retired_q;

endmodule
